// File: rtl/matmul_pkg.sv
// Shared types and sizing for the ternary matmul sequencer.
// Weights are 2-bit codes packed four per byte, LSB pair first.
package matmul_pkg;

`ifndef COMPUTE_SLICES
`define COMPUTE_SLICES 4
`endif
    localparam int COMPUTE_SLICES = `COMPUTE_SLICES;
    localparam int K     = 16;
    localparam int WB    = COMPUTE_SLICES * K / 4;
    localparam int WB_W  = $clog2(WB);
    localparam int K_W   = $clog2(K);
    localparam int S_W   = $clog2(COMPUTE_SLICES);
    // One index counter serves weight bytes, activations and result bytes.
    localparam int CNT_W = (WB_W > K_W) ? ((WB_W > S_W + 1) ? WB_W : S_W + 1)
                                        : ((K_W > S_W + 1) ? K_W : S_W + 1);

    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_A,
        WAIT,
        OUTPUT
    } state_t;

endpackage

// File: rtl/ternary_matmul_sequencer.sv
// Sequences weight load, accumulator clear, activation broadcast and result readout.
// Latency: strobes appear one cycle after the accepting edge; one WAIT cycle before readout.
// Backpressure: in_valid=0 or out_ready=0 freezes state and index; in_ready is combinational.
module ternary_matmul_sequencer
    import matmul_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            reload_w,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            w_we,
    output logic [WB_W-1:0] w_addr,
    output logic [7:0]      w_byte,
    output logic            acc_clear,
    output logic            acc_en,
    output logic [7:0]      act_data,
    output logic [K_W-1:0]  act_k,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [S_W-1:0]  out_slice,
    output logic            out_hi,
    output logic            busy,
    output logic            done
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   idx, idx_n, idx_inc;
    logic               weights_valid, weights_valid_n;
    logic               w_we_n, acc_clear_n, acc_en_n, out_valid_n, out_hi_n, done_n;
    logic [WB_W-1:0]    w_addr_n;
    logic [7:0]         w_byte_n, act_data_n;
    logic [K_W-1:0]     act_k_n;
    logic [S_W-1:0]     out_slice_n;
    logic               in_accept, out_accept;

    assign in_ready   = (state == LOAD_W) || (state == LOAD_A);
    assign in_accept  = in_valid && in_ready;
    assign out_accept = out_valid && out_ready;
    assign idx_inc    = idx + 1'b1;

    always_comb begin
        state_n         = state;
        idx_n           = idx;
        weights_valid_n = weights_valid;
        w_we_n          = 1'b0;
        acc_clear_n     = 1'b0;
        acc_en_n        = 1'b0;
        done_n          = 1'b0;
        w_addr_n        = w_addr;
        w_byte_n        = w_byte;
        act_data_n      = act_data;
        act_k_n         = act_k;
        out_valid_n     = out_valid;
        out_slice_n     = out_slice;
        out_hi_n        = out_hi;

        case (state)
            IDLE: begin
                if (start) begin
                    idx_n = '0;
                    if (reload_w || !weights_valid) begin
                        state_n = LOAD_W;
                    end else begin
                        state_n     = LOAD_A;
                        acc_clear_n = 1'b1;
                    end
                end
            end
            LOAD_W: begin
                if (in_accept) begin
                    w_we_n   = 1'b1;
                    w_addr_n = idx[WB_W-1:0];
                    w_byte_n = in_data;
                    if (idx == CNT_W'(WB - 1)) begin
                        state_n         = LOAD_A;
                        idx_n           = '0;
                        weights_valid_n = 1'b1;
                        acc_clear_n     = 1'b1;
                    end else begin
                        idx_n = idx_inc;
                    end
                end
            end
            LOAD_A: begin
                if (in_accept) begin
                    acc_en_n   = 1'b1;
                    act_data_n = in_data;
                    act_k_n    = idx[K_W-1:0];
                    if (idx == CNT_W'(K - 1)) begin
                        state_n = WAIT;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx_inc;
                    end
                end
            end
            WAIT: begin
                // The final acc_en is in flight this cycle; results are stable next cycle.
                state_n     = OUTPUT;
                idx_n       = '0;
                out_valid_n = 1'b1;
                out_slice_n = '0;
                out_hi_n    = 1'b0;
            end
            OUTPUT: begin
                if (out_accept) begin
                    if (idx == CNT_W'(2 * COMPUTE_SLICES - 1)) begin
                        state_n     = IDLE;
                        idx_n       = '0;
                        out_valid_n = 1'b0;
                        done_n      = 1'b1;
                    end else begin
                        idx_n       = idx_inc;
                        out_hi_n    = idx_inc[0];
                        out_slice_n = idx_inc[S_W:1];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            weights_valid <= 1'b0;
            w_we          <= 1'b0;
            w_addr        <= '0;
            w_byte        <= '0;
            acc_clear     <= 1'b0;
            acc_en        <= 1'b0;
            act_data      <= '0;
            act_k         <= '0;
            out_valid     <= 1'b0;
            out_slice     <= '0;
            out_hi        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            weights_valid <= weights_valid_n;
            w_we          <= w_we_n;
            w_addr        <= w_addr_n;
            w_byte        <= w_byte_n;
            acc_clear     <= acc_clear_n;
            acc_en        <= acc_en_n;
            act_data      <= act_data_n;
            act_k         <= act_k_n;
            out_valid     <= out_valid_n;
            out_slice     <= out_slice_n;
            out_hi        <= out_hi_n;
            busy          <= (state_n != IDLE);
            done          <= done_n;
        end
    end

endmodule

// File: tb/tb_ternary_matmul_sequencer.sv
// Bench for ternary_matmul_sequencer: randomized jobs checked against expected strobe lists.
module tb_ternary_matmul_sequencer;
    import matmul_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, reload_w, in_valid, out_ready;
    logic [7:0]      in_data;
    logic            in_ready, w_we, acc_clear, acc_en, out_valid, out_hi, busy, done;
    logic [WB_W-1:0] w_addr;
    logic [7:0]      w_byte, act_data;
    logic [K_W-1:0]  act_k;
    logic [S_W-1:0]  out_slice;

    ternary_matmul_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .reload_w(reload_w),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .w_we(w_we), .w_addr(w_addr), .w_byte(w_byte),
        .acc_clear(acc_clear), .acc_en(acc_en), .act_data(act_data), .act_k(act_k),
        .out_valid(out_valid), .out_ready(out_ready), .out_slice(out_slice),
        .out_hi(out_hi), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit model_wv = 1'b0;

    int obs_w[$];
    int obs_a[$];
    int n_clear;
    int clear_cyc;
    int n_done;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance to the next falling edge and log every strobe seen there.
    task automatic sample();
        @(negedge clk);
        cyc++;
        if (w_we) obs_w.push_back(int'(w_addr) * 256 + int'(w_byte));
        if (acc_clear) begin
            n_clear++;
            clear_cyc = cyc;
        end
        if (acc_en) obs_a.push_back(int'(act_k) * 256 + int'(act_data));
        if (done) n_done++;
    endtask

    function automatic logic [1:0] pick_w();
        case ($urandom_range(0, 2))
            0:       return W_ZERO;
            1:       return W_POS;
            default: return W_NEG;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {w_we, w_addr, w_byte, acc_clear, acc_en, act_data, act_k,
                               out_valid, out_slice, out_hi, done}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    // in_mode: 0 always valid, 1 toggling, 2 random. out_mode: 0 ready, 1 random.
    task automatic run_job(input bit reload, input int in_mode, input int out_mode,
                           input bit directed, input bit stall, input bit ign_start);
        bit   do_load;
        int   nw, idx, g, last_cyc, wlast_cyc, acc_cyc, pos, stall_left;
        bit   tgl;
        logic [7:0] stream[$];

        do_load = reload || !model_wv;
        nw = do_load ? WB : 0;
        for (int b = 0; b < nw; b++)
            stream.push_back(directed ? 8'(b) : {pick_w(), pick_w(), pick_w(), pick_w()});
        for (int k = 0; k < K; k++)
            stream.push_back(directed ? 8'(8'h80 + k) : 8'($urandom));
        obs_w.delete();
        obs_a.delete();
        n_clear = 0;
        n_done = 0;
        clear_cyc = -1;
        wlast_cyc = -1;

        start = 1'b1;
        reload_w = reload;
        sample();
        start = 1'b0;
        reload_w = 1'($urandom);
        check("busy_after_start", busy, 1);
        check("load_path", acc_clear, !do_load);

        idx = 0;
        g = 0;
        tgl = 1'b1;
        last_cyc = cyc;
        while (idx < stream.size() && g < 500) begin
            case (in_mode)
                0:       in_valid = 1'b1;
                1:       in_valid = tgl;
                default: in_valid = 1'($urandom);
            endcase
            tgl = ~tgl;
            in_data = stream[idx];
            if (in_valid && in_ready) begin
                if (idx == nw - 1) wlast_cyc = cyc;
                idx++;
                last_cyc = cyc;
            end
            sample();
            g++;
        end
        in_valid = 1'b0;
        in_data = 8'($urandom);
        check("feed_complete", idx, stream.size());

        g = 0;
        while (!out_valid && g < 20) begin
            sample();
            g++;
        end
        check("wait_len", cyc - last_cyc, 2);
        check("in_ready_in_output", in_ready, 0);

        pos = 0;
        g = 0;
        acc_cyc = cyc;
        stall_left = 3;
        while (pos < 2 * COMPUTE_SLICES && g < 200) begin
            check("out_valid", out_valid, 1);
            check("out_sel", {out_slice, out_hi}, pos);
            if (stall && pos == 3 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = (out_mode == 0) ? 1'b1 : 1'($urandom);
            end
            start = ign_start && (pos == 2);
            reload_w = 1'($urandom);
            if (out_ready) begin
                pos++;
                acc_cyc = cyc;
            end
            sample();
            g++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        check("out_count", pos, 2 * COMPUTE_SLICES);
        check("done_latency", cyc - acc_cyc, 1);
        check("done_pulse", done, 1);
        check("out_valid_after", out_valid, 0);
        check("busy_after", busy, 0);
        sample();
        check("done_one_cycle", done, 0);
        check("idle_in_ready", in_ready, 0);

        check("w_we_count", obs_w.size(), nw);
        for (int i = 0; i < obs_w.size() && i < nw; i++)
            check("w_we_entry", obs_w[i], i * 256 + int'(stream[i]));
        check("acc_clear_count", n_clear, 1);
        if (do_load) check("clear_after_weights", clear_cyc, wlast_cyc + 1);
        check("acc_en_count", obs_a.size(), K);
        for (int i = 0; i < obs_a.size() && i < K; i++)
            check("acc_en_entry", obs_a[i], i * 256 + int'(stream[nw + i]));
        check("done_count", n_done, 1);
        model_wv = 1'b1;
    endtask

    initial begin
        int n, g;
        rst_n = 1'b0;
        start = 1'b0;
        reload_w = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = 8'h00;
        repeat (4) begin
            @(negedge clk);
            start = 1'($urandom);
            reload_w = 1'($urandom);
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            in_data = 8'($urandom);
        end
        #1;
        check_all_zero("reset");
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        sample();

        run_job(1'b1, 0, 0, 1'b1, 1'b0, 1'b0);
        run_job(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        run_job(1'b0, 1, 0, 1'b0, 1'b1, 1'b1);
        run_job(1'b1, 2, 1, 1'b0, 1'b0, 1'b0);

        // Abort a job part-way through the activations.
        start = 1'b1;
        reload_w = 1'b0;
        sample();
        start = 1'b0;
        n = 0;
        g = 0;
        while (n < 7 && g < 50) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            if (in_ready) n++;
            sample();
            g++;
        end
        in_valid = 1'b0;
        check("partial_feed", n, 7);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_wv = 1'b0;
        sample();
        run_job(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int j = 0; j < 4; j++)
            run_job(1'($urandom), $urandom_range(0, 2), $urandom_range(0, 1),
                    1'b0, 1'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
